// File: rtl/adc_deser_pkg.sv
// Shared types and defaults for the DIGOUT lane deserialiser.
package adc_deser_pkg;

  localparam int unsigned LANE_W     = 5;
  localparam int unsigned DEF_NBITS  = 12;
  localparam int unsigned DEF_NLANES = 17;
  localparam int unsigned DEF_ROW_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_CAPTURE = 3'b010,
    S_HANDOFF = 3'b100
  } state_e;

endpackage

// File: rtl/adc_deser_lane.sv
// One serial lane: NBITS shift register filled LSB-first from the MSB end.
module adc_deser_lane #(
  parameter int unsigned NBITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [NBITS-1:0] q
);

  logic [NBITS-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_q <= '0;
    end else if (shift) begin
      sr_q <= {din, sr_q[NBITS-1:1]};
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/adc_digout_deser.sv
// Deserialises all DIGOUT lanes of a row, double-buffers it and drains one word per beat.
// Optional ramp checker on the output stream: define ADC_DESER_RAMP_CHECK_EN.
module adc_digout_deser
  import adc_deser_pkg::*;
#(
  parameter int unsigned NLANES = DEF_NLANES,
  parameter int unsigned NBITS  = DEF_NBITS,
  parameter int unsigned ROW_W  = DEF_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RST_BAR_LTCHD,
  input  logic              ADC_DATA_VALID,
  input  logic [NLANES-1:0] DIGOUT,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NBITS-1:0]  out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last,
  output logic              frame_done,
  output logic              overrun,
  output logic              frame_err,
  output logic [15:0]       err_cnt
);

  localparam int unsigned      CNT_W     = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic                         rst_bar_q, valid_q;
  logic                         start, bitstb;
  logic                         lane_clr, lane_shift, set_ferr, handoff;
  logic [NLANES-1:0][NBITS-1:0] sr;
  logic [NLANES-1:0][NBITS-1:0] hold_q;
  logic [ROW_W-1:0]             tag_q, row_cnt_q;
  logic                         pending_q;
  logic [LANE_W-1:0]            lane_idx_q;
  logic                         frame_done_q, overrun_q, frame_err_q;
  logic                         accept, lane_last, buf_free;

  assign start  = rst_bar_q & ~RST_BAR_LTCHD;
  assign bitstb = ~valid_q & ADC_DATA_VALID;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    adc_deser_lane #(
      .NBITS(NBITS)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (lane_clr),
      .shift(lane_shift),
      .din  (DIGOUT[i]),
      .q    (sr[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    lane_clr   = 1'b0;
    lane_shift = 1'b0;
    set_ferr   = 1'b0;
    handoff    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CAPTURE;
          bit_cnt_d = '0;
          lane_clr  = 1'b1;
        end
      end
      S_CAPTURE: begin
        // A row start beats a coincident bit strobe: that bit belongs to nothing.
        if (start) begin
          set_ferr  = 1'b1;
          bit_cnt_d = '0;
          lane_clr  = 1'b1;
        end else if (bitstb) begin
          lane_shift = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_HANDOFF;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_HANDOFF: begin
        handoff = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = pending_q & out_ready;
  assign lane_last = (lane_idx_q == LAST_LANE);
  assign buf_free  = ~pending_q | (accept & lane_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      rst_bar_q    <= 1'b1;
      valid_q      <= 1'b0;
      hold_q       <= '0;
      tag_q        <= '0;
      row_cnt_q    <= '0;
      pending_q    <= 1'b0;
      lane_idx_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rst_bar_q    <= RST_BAR_LTCHD;
      valid_q      <= ADC_DATA_VALID;
      frame_done_q <= 1'b0;
      if (set_ferr) frame_err_q <= 1'b1;
      if (accept) begin
        if (lane_last) begin
          lane_idx_q <= '0;
          pending_q  <= 1'b0;
        end else begin
          lane_idx_q <= lane_idx_q + LANE_W'(1);
        end
      end
      // Load after drain so a same-cycle final accept frees the buffer for this frame.
      if (handoff) begin
        row_cnt_q <= row_cnt_q + ROW_W'(1);
        if (buf_free) begin
          hold_q       <= sr;
          tag_q        <= row_cnt_q;
          pending_q    <= 1'b1;
          lane_idx_q   <= '0;
          frame_done_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = pending_q;
  assign out_data   = hold_q[lane_idx_q];
  assign out_lane   = lane_idx_q;
  assign out_row    = tag_q;
  assign out_last   = lane_last;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

`ifdef ADC_DESER_RAMP_CHECK_EN
  logic [NBITS-1:0] exp_q;
  logic [15:0]      err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= '0;
      err_cnt_q <= '0;
    end else if (accept) begin
      if ((out_data != exp_q) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (lane_last) exp_q <= exp_q + NBITS'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_digout_deser.sv
// Randomised bench for adc_digout_deser with a queue-based row/beat reference model.
module tb_adc_digout_deser;

  localparam int NL = 17;
  localparam int NB = 12;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_bar = 1'b1;
  logic          adc_valid = 1'b0;
  logic [NL-1:0] digout = '0;
  logic          out_ready = 1'b1;
  logic          out_valid, out_last, frame_done, overrun, frame_err;
  logic [NB-1:0] out_data;
  logic [4:0]    out_lane;
  logic [RW-1:0] out_row;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  adc_digout_deser dut (
    .clk           (clk),
    .rst           (rst),
    .RST_BAR_LTCHD (rst_bar),
    .ADC_DATA_VALID(adc_valid),
    .DIGOUT        (digout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane      (out_lane),
    .out_row       (out_row),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt)
  );

  typedef struct {
    logic [NB-1:0] data;
    logic [4:0]    lane;
    logic [RW-1:0] row;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            fd_cnt = 0;
  logic [RW-1:0] model_row = '0;
  logic [NB-1:0] frame_w [NL];

  // Scoreboard: every accepted beat must match the next expected word; stalled beats hold.
  logic                stall_q = 1'b0;
  logic [NB+5+RW:0]    stall_snap;
  beat_t               e;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (stall_q) begin
        tests++;
        if ({out_valid, out_data, out_lane, out_row} !== stall_snap) begin
          fails++;
          $display("FAIL stall_stable: got %h, want %h", {out_valid, out_data, out_lane, out_row},
                   stall_snap);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got lane %0d data %h row %0d, want no beat",
                   out_lane, out_data, out_row);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_lane, out_row, out_last} !== {e.data, e.lane, e.row, e.last}) begin
            fails++;
            $display("FAIL beat: got data %h lane %0d row %0d last %b, want %h %0d %0d %b",
                     out_data, out_lane, out_row, out_last, e.data, e.lane, e.row, e.last);
          end
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_snap = {1'b1, out_data, out_lane, out_row};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500us");
    $fatal(1);
  end

  task automatic push_frame(input logic [RW-1:0] row);
    beat_t b;
    for (int i = 0; i < NL; i++) begin
      b.data = frame_w[i];
      b.lane = 5'(i);
      b.row  = row;
      b.last = (i == NL - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < NL; i++) frame_w[i] = NB'($urandom);
  endtask

  task automatic do_start();
    @(posedge clk); #1 rst_bar = 1'b0;
    @(posedge clk); #1 rst_bar = 1'b1;
  endtask

  task automatic send_bit(input logic [NL-1:0] b);
    @(posedge clk); #1 digout = b; adc_valid = 1'b1;
    @(posedge clk); #1 adc_valid = 1'b0;
  endtask

  task automatic send_bits();
    logic [NL-1:0] bits;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NL; i++) bits[i] = frame_w[i][b];
      send_bit(bits);
    end
  endtask

  task automatic send_frame();
    do_start();
    send_bits();
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_row = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || out_valid) begin
      fails++;
      $display("FAIL drain_timeout: got %0d beats left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_lane, out_row, out_last, frame_done, overrun, frame_err,
         err_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid %b data %h lane %0d row %0d flags %b%b%b%b err %0d, want all 0",
               out_valid, out_data, out_lane, out_row, out_last, frame_done, overrun, frame_err,
               err_cnt);
    end
  endtask

  task automatic test_ramp();
    int fd0 = fd_cnt;
    for (int i = 0; i < NL; i++) frame_w[i] = '0;
    push_frame(model_row);
    model_row++;
    send_frame();
    @(negedge clk);
    tests++;
    if ({frame_done, out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL latency_early: got done/valid %b%b, want 00", frame_done, out_valid);
    end
    @(negedge clk);
    tests++;
    if ({frame_done, out_valid, out_lane} !== {2'b11, 5'd0}) begin
      fails++;
      $display("FAIL latency_2cyc: got done/valid %b%b lane %0d, want 11 lane 0",
               frame_done, out_valid, out_lane);
    end
    for (int i = 0; i < NL; i++) frame_w[i] = 12'h001;
    push_frame(model_row);
    model_row++;
    send_frame();
    wait_drain();
    tests++;
    if (fd_cnt - fd0 != 2) begin
      fails++;
      $display("FAIL ramp_frame_done: got %0d pulses, want 2", fd_cnt - fd0);
    end
    tests++;
    if (err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL ramp_err_cnt: got %0d, want 0", err_cnt);
    end
  endtask

  task automatic test_lane_pattern();
    for (int i = 0; i < NL; i++) frame_w[i] = 12'hA5A ^ NB'(i);
    push_frame(model_row);
    model_row++;
    send_frame();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_cnt;
    repeat (4) begin
      random_frame();
      push_frame(model_row);
      model_row++;
      send_frame();
    end
    wait_drain();
    tests++;
    if (fd_cnt - fd0 != 4) begin
      fails++;
      $display("FAIL b2b_frame_done: got %0d pulses, want 4", fd_cnt - fd0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    random_frame();
    push_frame(model_row);
    model_row++;
    fork
      send_frame();
      repeat (40) begin
        @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      end
    join
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_overrun();
    int            fd0 = fd_cnt;
    logic [RW-1:0] row_a = model_row;
    logic [NB-1:0] lane0_a;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre: got %b, want 0", overrun);
    end
    @(posedge clk); #1 out_ready = 1'b0;
    random_frame();
    lane0_a = frame_w[0];
    push_frame(model_row);
    model_row++;
    send_frame();
    random_frame();
    model_row++;
    send_frame();
    repeat (2) @(negedge clk);
    tests++;
    if ({overrun, out_valid, out_row, out_lane, out_data} !== {2'b11, row_a, 5'd0, lane0_a}) begin
      fails++;
      $display("FAIL overrun_hold: got ovr %b valid %b row %0d lane %0d data %h, want 1 1 %0d 0 %h",
               overrun, out_valid, out_row, out_lane, out_data, row_a, lane0_a);
    end
    tests++;
    if (fd_cnt - fd0 != 1) begin
      fails++;
      $display("FAIL overrun_frame_done: got %0d pulses, want 1", fd_cnt - fd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: got %b, want 1", overrun);
    end
  endtask

  task automatic test_frame_err();
    int fd0 = fd_cnt;
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_pre: got %b, want 0", frame_err);
    end
    do_start();
    repeat (5) send_bit(NL'($urandom));
    // Restart coincident with a stray bit: the bit must not be captured.
    @(posedge clk); #1 rst_bar = 1'b0; adc_valid = 1'b1; digout = NL'($urandom);
    @(posedge clk); #1 rst_bar = 1'b1; adc_valid = 1'b0;
    for (int i = 0; i < NL; i++) frame_w[i] = 12'h3C3;
    push_frame(model_row);
    model_row++;
    send_bits();
    wait_drain();
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL frame_err_set: got %b, want 1", frame_err);
    end
    tests++;
    if (fd_cnt - fd0 != 1) begin
      fails++;
      $display("FAIL frame_err_frame_done: got %0d pulses, want 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_rst_mid();
    do_start();
    repeat (5) send_bit(NL'($urandom));
    pulse_rst();
    @(negedge clk);
    tests++;
    if ({out_valid, overrun, frame_err, err_cnt} !== '0) begin
      fails++;
      $display("FAIL rst_capture: got valid %b ovr %b ferr %b err %0d, want 0 0 0 0",
               out_valid, overrun, frame_err, err_cnt);
    end
    random_frame();
    push_frame(model_row);
    model_row++;
    send_frame();
    repeat (7) @(negedge clk);
    pulse_rst();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_drain: got valid %b, want 0", out_valid);
    end
    random_frame();
    push_frame(model_row);
    model_row++;
    send_frame();
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, out_row} !== {1'b1, RW'(0)}) begin
      fails++;
      $display("FAIL rst_row_tag: got valid %b row %0d, want 1 0", out_valid, out_row);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_lane_pattern();
    test_back_to_back();
    test_backpressure();
    test_overrun();
    test_frame_err();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
